// File: rtl/time_display_driver_pkg.sv
// Shared constants for the time display: segment codes, digit slots and day one-hot values.
// The day constants are also used by the time keeper bench.
package time_display_pkg;

  localparam int unsigned C_NUM_DIGITS = 4;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] C_SEG_0     = 7'h40;
  localparam logic [6:0] C_SEG_1     = 7'h79;
  localparam logic [6:0] C_SEG_2     = 7'h24;
  localparam logic [6:0] C_SEG_3     = 7'h30;
  localparam logic [6:0] C_SEG_4     = 7'h19;
  localparam logic [6:0] C_SEG_5     = 7'h12;
  localparam logic [6:0] C_SEG_6     = 7'h02;
  localparam logic [6:0] C_SEG_7     = 7'h78;
  localparam logic [6:0] C_SEG_8     = 7'h00;
  localparam logic [6:0] C_SEG_9     = 7'h10;
  localparam logic [6:0] C_SEG_DASH  = 7'h3F;
  localparam logic [6:0] C_SEG_BLANK = 7'h7F;

  localparam logic [6:0] C_SUNDAY    = 7'b0000001;
  localparam logic [6:0] C_MONDAY    = 7'b0000010;
  localparam logic [6:0] C_TUESDAY   = 7'b0000100;
  localparam logic [6:0] C_WEDNESDAY = 7'b0001000;
  localparam logic [6:0] C_THURSDAY  = 7'b0010000;
  localparam logic [6:0] C_FRIDAY    = 7'b0100000;
  localparam logic [6:0] C_SATURDAY  = 7'b1000000;

  typedef enum logic [1:0] {
    DIG_MIN_UNITS  = 2'd0,
    DIG_MIN_TENS   = 2'd1,
    DIG_HOUR_UNITS = 2'd2,
    DIG_HOUR_TENS  = 2'd3
  } digit_e;

  function automatic logic is_one_hot(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/time_display_driver_hex_to_seven_seg.sv
// BCD digit to active-low 7-segment code; anything above 9 renders blank.
module hex_to_seven_seg
  import time_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = C_SEG_0;
      4'd1:    seg = C_SEG_1;
      4'd2:    seg = C_SEG_2;
      4'd3:    seg = C_SEG_3;
      4'd4:    seg = C_SEG_4;
      4'd5:    seg = C_SEG_5;
      4'd6:    seg = C_SEG_6;
      4'd7:    seg = C_SEG_7;
      4'd8:    seg = C_SEG_8;
      4'd9:    seg = C_SEG_9;
      default: seg = C_SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/time_display_driver.sv
// Front-panel driver: 12-hour multiplexed 4-digit display, day LEDs, PM and colon,
// with a blink overlay while the user is setting the time.
module time_display_driver
  import time_display_pkg::*;
#(
  parameter int unsigned g_clk_freq    = 20000,
  parameter int unsigned g_refresh_div = 50
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [6:0] i_day,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_minute,
  input  logic [5:0] i_second,
  input  logic       i_set_time_n,
  output logic [6:0] o_seg_n,
  output logic [3:0] o_dig_n,
  output logic [6:0] o_day_led,
  output logic       o_pm,
  output logic       o_colon
);

  if (g_clk_freq <= 1 || g_refresh_div <= 1) begin : g_bad_params
    $error("time_display_driver: g_clk_freq and g_refresh_div must be greater than 1");
  end

  localparam int unsigned SLOT_W  = $clog2(g_refresh_div);
  localparam int unsigned BLINK_W = $clog2(g_clk_freq);
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(g_refresh_div - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(g_clk_freq - 1);
  localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(g_clk_freq / 2);

  logic [6:0] day_q;
  logic [4:0] hour_q;
  logic [5:0] minute_q;
  logic [5:0] second_q;
  logic       set_n_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      day_q    <= '0;
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      set_n_q  <= 1'b1;
    end else begin
      day_q    <= i_day;
      hour_q   <= i_hour;
      minute_q <= i_minute;
      second_q <= i_second;
      set_n_q  <= i_set_time_n;
    end
  end

  logic unused_second_msbs;
  assign unused_second_msbs = ^second_q[5:1];

  // Held at zero outside set mode, so entering set mode always starts in the on phase.
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                 blink_cnt <= '0;
    else if (set_n_q)               blink_cnt <= '0;
    else if (blink_cnt == BLINK_LAST) blink_cnt <= '0;
    else                            blink_cnt <= blink_cnt + 1'b1;
  end

  digit_e            digit, digit_next;
  logic [SLOT_W-1:0] slot_cnt, slot_next;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      digit    <= DIG_MIN_UNITS;
      slot_cnt <= '0;
    end else begin
      digit    <= digit_next;
      slot_cnt <= slot_next;
    end
  end

  always_comb begin
    digit_next = digit;
    slot_next  = slot_cnt + 1'b1;
    if (slot_cnt == SLOT_LAST) begin
      slot_next = '0;
      case (digit)
        DIG_MIN_UNITS:  digit_next = DIG_MIN_TENS;
        DIG_MIN_TENS:   digit_next = DIG_HOUR_UNITS;
        DIG_HOUR_UNITS: digit_next = DIG_HOUR_TENS;
        default:        digit_next = DIG_MIN_UNITS;
      endcase
    end
  end

  logic       valid;
  logic [3:0] hour12;
  logic [3:0] hour_tens, hour_units, minute_units;
  logic [2:0] minute_tens;

  always_comb begin
    valid = (hour_q <= 5'd23) && (minute_q <= 6'd59);

    if (hour_q == 5'd0)       hour12 = 4'd12;
    else if (hour_q > 5'd12)  hour12 = 4'(hour_q - 5'd12);
    else                      hour12 = hour_q[3:0];

    hour_tens  = (hour12 >= 4'd10) ? 4'd1 : 4'hF;
    hour_units = (hour12 >= 4'd10) ? hour12 - 4'd10 : hour12;

    if (minute_q >= 6'd50)      minute_tens = 3'd5;
    else if (minute_q >= 6'd40) minute_tens = 3'd4;
    else if (minute_q >= 6'd30) minute_tens = 3'd3;
    else if (minute_q >= 6'd20) minute_tens = 3'd2;
    else if (minute_q >= 6'd10) minute_tens = 3'd1;
    else                        minute_tens = 3'd0;
    minute_units = 4'(minute_q - 6'd10 * {3'b000, minute_tens});
  end

  logic [3:0] bcd;
  logic [6:0] bcd_seg;

  hex_to_seven_seg u_hex_to_seven_seg (
    .bcd (bcd),
    .seg (bcd_seg)
  );

  logic [6:0] seg_d, day_d;
  logic [3:0] dig_d;
  logic       pm_d, colon_d, blank_d, blank_q, off;

  always_comb begin
    case (digit)
      DIG_MIN_UNITS:  bcd = minute_units;
      DIG_MIN_TENS:   bcd = {1'b0, minute_tens};
      DIG_HOUR_UNITS: bcd = hour_units;
      default:        bcd = hour_tens;
    endcase

    off     = blink_cnt >= BLINK_HALF;
    blank_d = valid && (digit == DIG_HOUR_TENS) && (hour12 < 4'd10);

    // Segment data changes only on the guard cycle, while all enables are off.
    seg_d = o_seg_n;
    dig_d = 4'hF;
    if (slot_cnt == '0)
      seg_d = valid ? bcd_seg : C_SEG_DASH;
    else if (!off && !blank_q)
      dig_d = ~(4'b0001 << digit);

    day_d   = (!off && is_one_hot(day_q)) ? day_q : '0;
    pm_d    = !off && valid && (hour_q >= 5'd12);
    colon_d = !off && !second_q[0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_seg_n   <= C_SEG_BLANK;
      o_dig_n   <= 4'hF;
      o_day_led <= '0;
      o_pm      <= 1'b0;
      o_colon   <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      o_seg_n   <= seg_d;
      o_dig_n   <= dig_d;
      o_day_led <= day_d;
      o_pm      <= pm_d;
      o_colon   <= colon_d;
      if (slot_cnt == '0) blank_q <= blank_d;
    end
  end

endmodule

// File: tb/tb_time_display_driver.sv
// Directed bench for time_display_driver with a short blink period and refresh slot.
module tb_time_display_driver;
  import time_display_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] day;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       set_n;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  logic [6:0] day_led;
  logic       pm;
  logic       colon;

  always #5 clk = ~clk;

  time_display_driver #(.g_clk_freq(4), .g_refresh_div(3)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_day        (day),
    .i_hour       (hour),
    .i_minute     (minute),
    .i_second     (second),
    .i_set_time_n (set_n),
    .o_seg_n      (seg_n),
    .o_dig_n      (dig_n),
    .o_day_led    (day_led),
    .o_pm         (pm),
    .o_colon      (colon)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [6:0] seg_seen [4];
  int         en_cnt   [4];
  logic       pm_seen;
  logic [6:0] day_seen;

  task automatic push(input string tag, input logic [31:0] exp);
    sb.push_back('{tag, exp});
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic push_frame(input string p, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int en3,
                            input logic exp_pm, input logic [6:0] exp_day);
    push({p, "_dig0"}, 32'(s0));
    push({p, "_dig1"}, 32'(s1));
    push({p, "_dig2"}, 32'(s2));
    push({p, "_dig3"}, 32'(s3));
    push({p, "_dig3_en"}, 32'(en3));
    push({p, "_pm"}, 32'(exp_pm));
    push({p, "_day"}, 32'(exp_day));
  endtask

  // Settle, then record one full frame of enabled digits.
  task automatic observe_and_compare_frame();
    repeat (14) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      seg_seen[d] = C_SEG_BLANK;
      en_cnt[d]   = 0;
    end
    repeat (12) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (dig_n === 4'(~(4'b0001 << d))) begin
          seg_seen[d] = seg_n;
          en_cnt[d]++;
        end
      end
      pm_seen  = pm;
      day_seen = day_led;
    end
    for (int d = 0; d < 4; d++) compare(32'(seg_seen[d]));
    compare(32'(en_cnt[3]));
    compare(32'(pm_seen));
    compare(32'(day_seen));
  endtask

  task automatic check_reset_outputs(input string p);
    push({p, "_seg"}, 32'h7F);   compare(32'(seg_n));
    push({p, "_dig"}, 32'hF);    compare(32'(dig_n));
    push({p, "_day"}, 32'h0);    compare(32'(day_led));
    push({p, "_pm"}, 32'h0);     compare(32'(pm));
    push({p, "_colon"}, 32'h0);  compare(32'(colon));
  endtask

  // Called at a negedge with reset low; first slot after release is a dig0 guard cycle.
  task automatic release_and_check(input string p);
    rst_n = 1'b1;
    push({p, "_guard_dig"}, 32'hF);
    push({p, "_guard_seg"}, 32'h40);
    push({p, "_first_en"}, 32'hE);
    @(negedge clk);
    compare(32'(dig_n));
    compare(32'(seg_n));
    @(negedge clk);
    compare(32'(dig_n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic on;
    rst_n  = 1'b0;
    day    = C_SUNDAY;
    hour   = 5'd0;
    minute = 6'd0;
    second = 6'd1;
    set_n  = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_and_check("por_rel");

    // Reset asserted mid-slot, between clock edges.
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_async");
    @(negedge clk);
    check_reset_outputs("mid_held");
    release_and_check("mid_rel");

    hour = 5'd16; minute = 6'd37; day = C_SATURDAY;
    push_frame("h16", 7'h78, 7'h30, 7'h19, 7'h7F, 0, 1'b1, C_SATURDAY);
    observe_and_compare_frame();

    hour = 5'd0; minute = 6'd5; day = C_MONDAY;
    push_frame("h00", 7'h12, 7'h40, 7'h24, 7'h79, 2, 1'b0, C_MONDAY);
    observe_and_compare_frame();

    hour = 5'd12;
    push_frame("h12", 7'h12, 7'h40, 7'h24, 7'h79, 2, 1'b1, C_MONDAY);
    observe_and_compare_frame();

    hour = 5'd24; minute = 6'd0; day = 7'b0000011;
    push_frame("h24", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 2, 1'b0, 7'h00);
    observe_and_compare_frame();

    hour = 5'd16; minute = 6'd60; day = C_SATURDAY;
    push_frame("m60", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 2, 1'b0, C_SATURDAY);
    observe_and_compare_frame();

    hour = 5'd16; minute = 6'd37;
    second = 6'd4;
    repeat (3) @(negedge clk);
    push("colon_s4", 32'h1); compare(32'(colon));

    second = 6'd5;
    push("colon_s5_c1", 32'h1); push("colon_s5_c2", 32'h0);
    @(negedge clk); compare(32'(colon));
    @(negedge clk); compare(32'(colon));

    second = 6'd6;
    push("colon_s6_c1", 32'h0); push("colon_s6_c2", 32'h1);
    @(negedge clk); compare(32'(colon));
    @(negedge clk); compare(32'(colon));

    // Set mode: 2 cycles on, 2 off, starting one capture cycle after the input falls.
    set_n = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      on = (k == 1) || (((k - 2) % 4) < 2);
      push($sformatf("blink_day_%0d", k), on ? 32'h40 : 32'h0);
      compare(32'(day_led));
      if (!on) begin
        push($sformatf("blink_dig_%0d", k), 32'hF);
        compare(32'(dig_n));
      end
    end
    set_n = 1'b1;
    @(negedge clk);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      push($sformatf("solid_day_%0d", k), 32'h40);
      compare(32'(day_led));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
- Consumer side of the time keeper's time bus: takes day (one-hot), hour, minute and second, and drives a 4-digit multiplexed common-anode 7-segment display plus 7 day LEDs, a PM LED and a colon.
- Renders a 12-hour clock with leading-zero blanking, scans the digits at a fixed refresh rate, and blinks the display while the user is setting the time.
- Sits between the time keeper outputs and the front-panel pins of the thermostat.

Parameters:
- g_clk_freq, 20000, clock cycles per second; sets the blink period.
- g_refresh_div, 50, clock cycles per digit slot (400 Hz per slot, 100 Hz per frame).

Ports:
- i_clk  in  1  system clock (20 kHz)
- i_reset_n  in  1  asynchronous reset, active low
- i_day  in  7  one-hot day; bit0 = Sunday, bit6 = Saturday
- i_hour  in  5  hour, 0-23 binary
- i_minute  in  6  minute, 0-59 binary
- i_second  in  6  second, 0-59 binary
- i_set_time_n  in  1  set-time mode, active low
- o_seg_n  out  7  segments {g,f,e,d,c,b,a}, active low
- o_dig_n  out  4  digit enables, active low; dig0 = minute units, dig3 = hour tens
- o_day_led  out  7  day LEDs, active high, same bit order as i_day
- o_pm  out  1  PM indicator, active high
- o_colon  out  1  colon LED, active high

Behaviour:
- Reset (asynchronous, i_reset_n low): o_seg_n=7'h7F, o_dig_n=4'hF, o_day_led=0, o_pm=0, o_colon=0; all counters and the digit index cleared. After release, the first slot is dig0.
- Input capture: all time inputs and i_set_time_n are registered every cycle. Outputs reflect a change 2 cycles after the input change (1 capture stage plus 1 output stage), or at the next slot boundary for segment data.
- 12-hour mapping:
  - hour 0 displays 12, AM.
  - hours 1-11 display 1-11, AM.
  - hour 12 displays 12, PM.
  - hours 13-23 display h-12, PM.
  - o_pm=1 for hours 12-23.
- BCD: hour tens is blanked when zero (segments 7'h7F and dig3 enable held off). Minute tens and units are always shown.
- Out of range (hour>23 or minute>59): all four digits show a dash (7'h3F); o_pm=0.
- Segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex, active low).
- Day LEDs: o_day_led = captured i_day when it is exactly one-hot; otherwise 0.
- Colon: o_colon = ~captured second[0], so it is on during even seconds.
- Scan state machine: digit index 0→1→2→3→0; each slot lasts g_refresh_div cycles.
  - First cycle of a slot is a guard cycle: o_dig_n=4'hF and o_seg_n loaded with the new digit's code.
  - Remaining cycles: the one active-low enable for the current digit, unless the digit is blanked.
- Blink counter: 0 to g_clk_freq-1, wrapping.
  - Runs only while the captured set-mode signal is low.
  - Cleared the cycle set mode is entered, so the display starts in the on phase.
  - Held at 0 while not in set mode.
  - Off phase is count >= g_clk_freq/2: o_dig_n=4'hF, o_day_led=0, o_pm=0, o_colon=0.
  - The scan continues through the off phase.
- Simultaneous events: a time change in the same cycle as a slot boundary uses the newly captured value from the next slot onward; a torn display within one frame is acceptable.
- Parameters of 1 or less are illegal (elaboration assertion).

Decomposition:
- Shared package time_display_pkg:
  - segment code constants C_SEG_0..C_SEG_9, C_SEG_DASH, C_SEG_BLANK
  - C_NUM_DIGITS=4
  - day one-hot constants C_SUNDAY..C_SATURDAY, shared with the time keeper bench
- One combinational sub-module: hex_to_seven_seg (4-bit BCD in, 7-bit active-low segments out, codes above 9 produce C_SEG_BLANK).

Test Plan (g_clk_freq=4, g_refresh_div=3):
- Reset held mid-frame → next cycle o_dig_n=F, o_seg_n=7F, o_day_led=0; after release, the first enabled digit is dig0 on the second slot cycle.
- hour=16, minute=37, day=7'b1000000 → over one frame:
  - dig0 shows 78, dig1 shows 30, dig2 shows 19
  - dig3 never enabled
  - o_pm=1, o_day_led=7'b1000000
- hour=0, minute=5 → dig3=79, dig2=24, dig1=40, dig0=12, o_pm=0; hour=12 gives the same digits with o_pm=1.
- i_set_time_n low for 12 cycles → enables active for 2 cycles, then all F for 2 cycles, repeating; on release, solid display within 2 cycles.
- hour=24 or minute=60 → all enabled digits show 3F; i_day=7'b0000011 → o_day_led=0.
- second stepping 4→5→6 → o_colon goes 1→0→1, each transition 2 cycles after the input change.
